// File: rtl/md_sequencer.sv
// ---------------------------------------------------------------------------
// md_sequencer
//
// Multi-cycle multiply/divide sequencer and owner of the architectural HI/LO
// registers for the E stage. One mult/multu/div/divu is accepted per start;
// its 64-bit result is computed when the operation is issued, parked in a
// pending register, and committed to HI/LO only once the modelled latency has
// elapsed. mthi/mtlo write HI/LO directly in the issue cycle. A CP0 request
// coinciding with start flushes the instruction, so it has no effect at all.
//
// Ports:
//   clk    in   1   clock
//   reset  in   1   synchronous, active-high reset (wins over everything)
//   start  in   1   issue md/mt operation this cycle
//   op     in   3   0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 no-op
//   a      in  32   rs operand (forwarded)
//   b      in  32   rt operand (forwarded)
//   req    in   1   CP0 exception/interrupt request, flushes E this cycle
//   hi     out 32   architectural HI
//   lo     out 32   architectural LO
//   busy   out  1   operation in flight (registered)
//   done   out  1   one-cycle pulse, HI/LO just committed by mult/div
// ---------------------------------------------------------------------------
module md_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t      state_r, state_s;
    logic [3:0]  cnt_r, cnt_s;
    logic [31:0] hi_r, hi_s;
    logic [31:0] lo_r, lo_s;
    logic [31:0] pend_hi_r, pend_hi_s;
    logic [31:0] pend_lo_r, pend_lo_s;
    logic        busy_r, busy_s;
    logic        done_r, done_s;
    logic [63:0] result_s;

    // Full {hi, lo} result of a mult/div operation. Divide by zero and the
    // signed -2^31 / -1 overflow are given their architectural values; the
    // divisor fed to the dividers is forced to 1 in those cases so the
    // hardware dividers never see an undefined operation.
    function automatic logic [63:0] md_compute(
        input logic [2:0]  f_op,
        input logic [31:0] f_a,
        input logic [31:0] f_b
    );
        logic signed [63:0] s_prod;
        logic [63:0]        u_prod;
        logic signed [31:0] s_div;
        logic signed [31:0] s_q;
        logic signed [31:0] s_r;
        logic [31:0]        u_div;
        logic [31:0]        u_q;
        logic [31:0]        u_r;
        logic               b_zero;
        logic               s_ovf;
        logic [63:0]        res;

        b_zero = (f_b == 32'd0);
        s_ovf  = (f_a == 32'h8000_0000) && (f_b == 32'hFFFF_FFFF);

        s_prod = $signed({{32{f_a[31]}}, f_a}) * $signed({{32{f_b[31]}}, f_b});
        u_prod = {32'd0, f_a} * {32'd0, f_b};

        s_div = (b_zero || s_ovf) ? 32'sd1 : $signed(f_b);
        s_q   = $signed(f_a) / s_div;
        s_r   = $signed(f_a) % s_div;

        u_div = b_zero ? 32'd1 : f_b;
        u_q   = f_a / u_div;
        u_r   = f_a % u_div;

        case (f_op)
            OP_MULT:  res = s_prod;
            OP_MULTU: res = u_prod;
            OP_DIV: begin
                if (b_zero) begin
                    res = {f_a, 32'hFFFF_FFFF};
                end else if (s_ovf) begin
                    res = {32'd0, 32'h8000_0000};
                end else begin
                    res = {s_r, s_q};
                end
            end
            OP_DIVU: begin
                if (b_zero) begin
                    res = {f_a, 32'hFFFF_FFFF};
                end else begin
                    res = {u_r, u_q};
                end
            end
            default:  res = 64'd0;
        endcase
        return res;
    endfunction

    // Next-state and next-output logic for the IDLE/RUN sequencer.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        pend_hi_s = pend_hi_r;
        pend_lo_s = pend_lo_r;
        done_s    = 1'b0;
        result_s  = md_compute(op, a, b);

        case (state_r)
            ST_IDLE: begin
                // A flushed instruction (req) must leave every register as is.
                if (start && !req) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            pend_hi_s = result_s[63:32];
                            pend_lo_s = result_s[31:0];
                            cnt_s     = MULT_CNT;
                            state_s   = ST_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            pend_hi_s = result_s[63:32];
                            pend_lo_s = result_s[31:0];
                            cnt_s     = DIV_CNT;
                            state_s   = ST_RUN;
                        end
                        OP_MTHI: hi_s = a;
                        OP_MTLO: lo_s = a;
                        default: state_s = ST_IDLE;
                    endcase
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start and req are ignored here: the operation has left E.
                if (cnt_r == 4'd1) begin
                    hi_s    = pend_hi_r;
                    lo_s    = pend_lo_r;
                    cnt_s   = 4'd0;
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r - 4'd1;
                end
            end
            default: begin
                cnt_s   = 4'd0;
                state_s = ST_IDLE;
            end
        endcase

        busy_s = (state_s == ST_RUN);
    end

    // State, counter, HI/LO, pending result and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            pend_hi_r <= 32'd0;
            pend_lo_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            pend_hi_r <= pend_hi_s;
            pend_lo_r <= pend_lo_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
        end
    end

    assign hi   = hi_r;
    assign lo   = lo_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_md_sequencer.sv
// ---------------------------------------------------------------------------
// tb_md_sequencer
//
// Directed and randomized checks of md_sequencer against a reference model
// that computes HI/LO from plain 64-bit arithmetic and tracks latency with a
// simple per-operation cycle count.
// ---------------------------------------------------------------------------
module tb_md_sequencer;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int          total;
    int          bad;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_sequencer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .req   (req),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result {hi, lo} computed with 64-bit integer arithmetic.
    function automatic logic [63:0] ref_md(input logic [2:0] o,
                                           input logic [31:0] va,
                                           input logic [31:0] vb);
        longint          sa;
        longint          sb;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned uq;
        longint unsigned ur;
        logic [63:0]     res;
        sa = longint'($signed(va));
        sb = longint'($signed(vb));
        ua = {32'd0, va};
        ub = {32'd0, vb};
        res = 64'd0;
        case (o)
            3'd0: res = sa * sb;
            3'd1: res = ua * ub;
            3'd2: begin
                if (vb == 32'd0) res = {va, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa - q * sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            3'd3: begin
                if (vb == 32'd0) res = {va, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    ur = ua - uq * ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
            default: res = 64'd0;
        endcase
        return res;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic exp_busy, input logic exp_done);
        chk({tag, "_busy"}, {31'd0, busy}, {31'd0, exp_busy});
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_hi"}, hi, m_hi);
        chk({tag, "_lo"}, lo, m_lo);
    endtask

    // One cycle of a non-sequenced op (mt, no-op, or anything flushed by req).
    task automatic do_single(input logic [2:0] o, input logic [31:0] va,
                             input logic [31:0] vb, input logic rq);
        start = 1'b1; op = o; a = va; b = vb; req = rq;
        step();
        start = 1'b0; req = 1'b0;
        if (!rq && o == 3'd4) m_hi = va;
        if (!rq && o == 3'd5) m_lo = va;
        chk_all("single", 1'b0, 1'b0);
    endtask

    // A full mult/div: busy for LAT cycles with HI/LO held, then commit + done.
    // req_at / mt_at pulse req or an mtlo start in that busy cycle (0 = none).
    task automatic do_md(input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input int req_at, input int mt_at);
        logic [63:0] r;
        int          lat;
        r   = ref_md(o, va, vb);
        lat = (o < 3'd2) ? MULT_LAT : DIV_LAT;
        start = 1'b1; op = o; a = va; b = vb; req = 1'b0;
        step();
        start = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            chk_all("run", 1'b1, 1'b0);
            req   = (k == req_at);
            start = (k == mt_at);
            if (k == mt_at) begin
                op = 3'd5;
                a  = 32'd9;
            end
            step();
            req   = 1'b0;
            start = 1'b0;
        end
        m_hi = r[63:32];
        m_lo = r[31:0];
        chk_all("commit", 1'b0, 1'b1);
    endtask

    initial begin
        logic [2:0]  r_op;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic        r_req;

        total = 0; bad = 0;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; req = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        step();
        step();
        chk_all("reset", 1'b0, 1'b0);
        reset = 1'b0;
        step();
        chk_all("post_reset", 1'b0, 1'b0);

        // mthi flushed by req, then accepted.
        do_single(3'd4, 32'h1234_5678, 32'd0, 1'b1);
        chk("mthi_flushed", hi, 32'd0);
        do_single(3'd4, 32'h1234_5678, 32'd0, 1'b0);
        chk("mthi_hi", hi, 32'h1234_5678);
        step();
        chk_all("mthi_after", 1'b0, 1'b0);

        // mult -3 * 5, done must be a single-cycle pulse.
        do_md(3'd0, 32'hFFFF_FFFD, 32'd5, 0, 0);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFF1);
        step();
        chk_all("mult_done_fall", 1'b0, 1'b0);

        // divu 7/2 then div -7/2 issued in the done cycle.
        do_md(3'd3, 32'd7, 32'd2, 0, 0);
        chk("divu_lo", lo, 32'd3);
        chk("divu_hi", hi, 32'd1);
        do_md(3'd2, 32'hFFFF_FFF9, 32'd2, 0, 0);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // Divide by zero and signed overflow.
        do_md(3'd2, 32'h0000_ABCD, 32'd0, 0, 0);
        chk("div0_lo", lo, 32'hFFFF_FFFF);
        chk("div0_hi", hi, 32'h0000_ABCD);
        do_md(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        chk("ovf_lo", lo, 32'h8000_0000);
        chk("ovf_hi", hi, 32'd0);

        // multu max*max with req in busy cycle 2 and mtlo in busy cycle 3.
        do_md(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 3);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'd1);

        // Reset in busy cycle 4 of a divu discards the pending result.
        start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
        step();
        start = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            chk_all("pre_rst_run", 1'b1, 1'b0);
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk_all("mid_reset", 1'b0, 1'b0);
        for (int k = 0; k < 12; k++) begin
            step();
            chk_all("after_reset", 1'b0, 1'b0);
        end

        // Randomized traffic with some corner-case operands mixed in.
        for (int n = 0; n < 60; n++) begin
            r_op  = 3'($urandom_range(0, 7));
            r_a   = $urandom;
            r_b   = $urandom;
            r_req = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            if (r_op <= 3'd3 && !r_req) do_md(r_op, r_a, r_b, 0, 0);
            else do_single(r_op, r_a, r_b, r_req);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
